// File: rtl/led_seq_if.sv
// Bundles the LED sequencer's run controls and its LED/step outputs.
// With LED_SEQ_PWM_EN defined, the bundle also carries the 8-bit brightness duty.
interface led_seq_if #(
  parameter int NUM_LEDS = 3
);
  logic                en;
  logic [1:0]          mode;
  logic [NUM_LEDS-1:0] leds;
  logic                step;
`ifdef LED_SEQ_PWM_EN
  logic [7:0]          duty;

  modport master (output en, output mode, output duty, input leds, input step);
  modport slave  (input en, input mode, input duty, output leds, output step);
`else
  modport master (output en, output mode, input leds, input step);
  modport slave  (input en, input mode, output leds, output step);
`endif
endinterface

// File: rtl/led_sequencer.sv
// LED pattern generator: chase up/down, bounce and blink-all, stepped by a built-in prescaler.
// Optional macro LED_SEQ_PWM_EN adds duty-cycle dimming of the registered pattern.
module led_sequencer #(
  parameter int NUM_LEDS    = 3,
  parameter int TICK_CYCLES = 100000000,
  parameter int CNT_W       = 32
) (
  input  logic      clk,
  input  logic      rst,
  led_seq_if.slave  bus
);

  localparam int                  POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]    POS_PREV = POS_W'(NUM_LEDS - 2);
  localparam logic [NUM_LEDS-1:0] ALL_ON   = '1;
  localparam logic [NUM_LEDS-1:0] LED0_ON  = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    MODE_UP    = 2'b00,
    MODE_DOWN  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  typedef enum logic { DIR_UP = 1'b0, DIR_DOWN = 1'b1 } dir_e;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  dir_e                dir_q, dir_d;
  mode_e               mode_q, mode_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic                step_q, step_d;
  logic                tick;

  function automatic logic [NUM_LEDS-1:0] one_hot(input logic [POS_W-1:0] p);
    return LED0_ON << p;
  endfunction

  always_comb begin
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    pat_d   = pat_q;
    step_d  = 1'b0;
    tick    = bus.en && (cnt_q == CNT_LAST);

    if (bus.en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    if (tick) begin
      step_d = 1'b1;
      if (mode_e'(bus.mode) != mode_q) begin
        // A new mode always restarts from its own start pattern.
        mode_d  = mode_e'(bus.mode);
        pos_d   = '0;
        dir_d   = DIR_UP;
        phase_d = (bus.mode == MODE_BLINK);
        pat_d   = (bus.mode == MODE_BLINK) ? ALL_ON : LED0_ON;
      end else begin
        unique case (mode_q)
          MODE_UP: begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
            pat_d = one_hot(pos_d);
          end
          MODE_DOWN: begin
            pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
            pat_d = one_hot(pos_d);
          end
          MODE_BOUNCE: begin
            // Turn around at an endpoint by moving straight to its neighbour.
            if (NUM_LEDS == 1) begin
              pos_d = '0;
            end else if (dir_q == DIR_UP) begin
              if (pos_q == POS_LAST) begin
                dir_d = DIR_DOWN;
                pos_d = POS_PREV;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = DIR_UP;
                pos_d = POS_W'(1);
              end else begin
                pos_d = pos_q - POS_W'(1);
              end
            end
            pat_d = one_hot(pos_d);
          end
          default: begin
            phase_d = ~phase_q;
            pat_d   = phase_d ? ALL_ON : '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= MODE_UP;
      phase_q <= 1'b0;
      pat_q   <= LED0_ON;
      step_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      pat_q   <= pat_d;
      step_q  <= step_d;
    end
  end

  assign bus.step = step_q;

`ifdef LED_SEQ_PWM_EN
  logic [7:0]          pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;

  // Dimming stage: pattern gated by the free-running PWM compare, one cycle behind.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    leds_d    = pat_q & {NUM_LEDS{pwm_cnt_q < bus.duty}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      leds_q    <= LED0_ON;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      leds_q    <= leds_d;
    end
  end

  assign bus.leds = leds_q;
`else
  assign bus.leds = pat_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer (NUM_LEDS=4, TICK_CYCLES=4) with a step-count model
// checked every cycle and literal expectations at each pattern change.
module tb_led_sequencer;

  localparam int N = 4;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  led_seq_if #(.NUM_LEDS(N)) bus ();

  led_sequencer #(.NUM_LEDS(N), .TICK_CYCLES(T), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: the pattern is a pure function of the active mode and the number of
  // steps taken since that mode was entered.
  int         m_ecnt = 0;
  int         m_k = 0;
  int         m_mode = 0;
  logic       m_step = 1'b0;
  logic [N-1:0] m_leds = 4'b0001;

  function automatic logic [N-1:0] pattern_of(input int md, input int k);
    int p;
    logic [N-1:0] one;
    one = 4'b0001;
    case (md)
      0: p = k % N;
      1: p = (N - (k % N)) % N;
      2: begin
        p = k % (2 * N - 2);
        if (p >= N) p = 2 * N - 2 - p;
      end
      default: return ((k % 2) == 0) ? 4'b1111 : 4'b0000;
    endcase
    return one << p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ecnt = 0; m_k = 0; m_mode = 0; m_step = 1'b0;
    end else begin
      m_step = 1'b0;
      if (bus.en) begin
        if (m_ecnt == T - 1) begin
          m_ecnt = 0;
          m_step = 1'b1;
          if (int'(bus.mode) != m_mode) begin
            m_mode = int'(bus.mode);
            m_k = 0;
          end else begin
            m_k++;
          end
        end else begin
          m_ecnt++;
        end
      end
    end
    m_leds = pattern_of(m_mode, m_k);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_leds", 32'(bus.leds), 32'(m_leds));
      check("model_step", 32'(bus.step), 32'(m_step));
    end
  end

  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.step && n < 50);
    if (!bus.step) begin
      checks++;
      errors++;
      $display("FAIL step_timeout: got no step after %0d cycles, required one", n);
    end
  endtask

  task automatic run_steps(input string nm, input logic [N-1:0] exp[$], input int gap);
    int n;
    foreach (exp[i]) begin
      wait_step(n);
      check({nm, "_leds"}, 32'(bus.leds), 32'(exp[i]));
      check({nm, "_gap"}, n, gap);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.mode = 2'b00;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_leds", 32'(bus.leds), 32'h1);
    check("reset_step", 32'(bus.step), 32'h0);

    rst = 1'b0;
    bus.en = 1'b1;
    run_steps("chase_up", '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100}, T);

    bus.mode = 2'b11;
    run_steps("blink", '{4'b1111, 4'b0000, 4'b1111, 4'b0000}, T);

    bus.mode = 2'b01;
    run_steps("chase_down", '{4'b0001, 4'b1000, 4'b0100}, T);

    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("freeze_leds", 32'(bus.leds), 32'h4);
      check("freeze_step", 32'(bus.step), 32'h0);
    end
    bus.en = 1'b1;
    wait_step(n);
    check("resume_gap", n, 2);
    check("resume_leds", 32'(bus.leds), 32'h2);

    rst = 1'b1;
    @(negedge clk);
    check("rst2_leds", 32'(bus.leds), 32'h1);
    rst = 1'b0;
    bus.mode = 2'b10;
    run_steps("bounce", '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
                          4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100}, T);

    @(negedge clk);
    rst = 1'b1;
    bus.mode = 2'b00;
    @(negedge clk);
    check("midrst_leds", 32'(bus.leds), 32'h1);
    check("midrst_step", 32'(bus.step), 32'h0);
    rst = 1'b0;
    run_steps("restart", '{4'b0010, 4'b0100}, T);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
